// File: rtl/tank_ctrl_conditioner_pkg.sv
// tank_ctrl_pkg: shared definitions for the tank control conditioner.
//   - joystick word bit indices (JOY_RIGHT .. JOY_COIN)
//   - tread_t {fw, bk}, stick_t {up, down, left, right}, tread_pair_t
//   - coin pulse FSM states
//   - map_stick(): 4/8-way stick to two-lever tread commands
package tank_ctrl_pkg;

  localparam int unsigned JOY_RIGHT  = 0;
  localparam int unsigned JOY_LEFT   = 1;
  localparam int unsigned JOY_DOWN   = 2;
  localparam int unsigned JOY_UP     = 3;
  localparam int unsigned JOY_FIRE   = 4;
  localparam int unsigned JOY_START1 = 5;
  localparam int unsigned JOY_START2 = 6;
  localparam int unsigned JOY_COIN   = 7;

  typedef struct packed {
    logic fw;
    logic bk;
  } tread_t;

  // Bit order matches joystick word [3:0]: {up, down, left, right}.
  typedef logic [3:0] stick_t;

  // a = first tread (W/Y), b = second tread (X/Z).
  typedef struct packed {
    tread_t a;
    tread_t b;
  } tread_pair_t;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } coin_state_t;

  function automatic tread_pair_t map_stick(input stick_t s);
    tread_pair_t t;
    t = '0;
    unique case (s)
      4'b1000: begin t.a.fw = 1'b1; t.b.fw = 1'b1; end  // up
      4'b1010: t.b.fw = 1'b1;                           // up-left
      4'b1001: t.a.fw = 1'b1;                           // up-right
      4'b0001: begin t.a.fw = 1'b1; t.b.bk = 1'b1; end  // right
      4'b0010: begin t.a.bk = 1'b1; t.b.fw = 1'b1; end  // left
      4'b0100: begin t.a.bk = 1'b1; t.b.bk = 1'b1; end  // down
      4'b0101: t.a.bk = 1'b1;                           // down-right
      4'b0110: t.b.bk = 1'b1;                           // down-left
      default: t = '0;                                  // none / conflicting
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tank_ctrl_conditioner_debounce.sv
// ctrl_debounce: one-bit debouncer.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (filtered value and counter clear)
//   raw_i  : raw input
//   filt_o : filtered value; follows raw_i after DEBOUNCE_CYCLES stable cycles
module ctrl_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 12000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic filt_o
);

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (raw_i != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = raw_i;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/tank_ctrl_conditioner.sv
// tank_ctrl_conditioner: input conditioning in front of the ultra_tank core.
// Debounces both joystick words, maps each stick onto two tread levers,
// registers fire/start, and shapes coin presses into rate-limited pulses.
// Ports:
//   clk_sys, reset           : clock, synchronous active-high reset
//   joy1, joy2 [15:0]        : MiSTer joystick words (bits 7:0 used)
//   joy{w,x,y,z}_{fw,bk}_n   : tread levers, active-low (w/x = P1, y/z = P2)
//   fire_a, fire_b           : fire buttons, active-high
//   start1_n, start2_n       : start buttons, active-low (either player)
//   coin_n                   : shaped coin pulse, active-low
//   coins_pending [1:0]      : queued coin count
// Optional feature: define TANK_CTRL_AUTOFIRE_EN for autofire on held fire.
module tank_ctrl_conditioner
  import tank_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 12000,
  parameter int unsigned COIN_PULSE_CYCLES = 600000,
  parameter int unsigned COIN_GAP_CYCLES   = 600000,
  parameter int unsigned AUTOFIRE_CYCLES   = 1200000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [15:0] joy1,
  input  logic [15:0] joy2,
  output logic        joyw_fw_n,
  output logic        joyw_bk_n,
  output logic        joyx_fw_n,
  output logic        joyx_bk_n,
  output logic        joyy_fw_n,
  output logic        joyy_bk_n,
  output logic        joyz_fw_n,
  output logic        joyz_bk_n,
  output logic        fire_a,
  output logic        fire_b,
  output logic        start1_n,
  output logic        start2_n,
  output logic        coin_n,
  output logic [1:0]  coins_pending
);

  localparam int unsigned COIN_MAX = (COIN_PULSE_CYCLES > COIN_GAP_CYCLES) ?
                                     COIN_PULSE_CYCLES : COIN_GAP_CYCLES;
  localparam int unsigned   CW         = $clog2(COIN_MAX) + 1;
  localparam logic [CW-1:0] PULSE_LAST = CW'(COIN_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(COIN_GAP_CYCLES - 1);

  // Raw vector layout: [4:0] P1 {fire,up,down,left,right}, [9:5] P2 same,
  // [10] start1, [11] start2, [12] coin (start/coin OR-ed across players).
  localparam int unsigned NDB = 13;

  logic [NDB-1:0] raw, filt;

  assign raw = {joy1[JOY_COIN]   | joy2[JOY_COIN],
                joy1[JOY_START2] | joy2[JOY_START2],
                joy1[JOY_START1] | joy2[JOY_START1],
                joy2[4:0],
                joy1[4:0]};

  logic unused_joy_hi;
  assign unused_joy_hi = ^{joy1[15:8], joy2[15:8]};

  for (genvar g = 0; g < NDB; g++) begin : g_db
    ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk_i  (clk_sys),
      .rst_i  (reset),
      .raw_i  (raw[g]),
      .filt_o (filt[g])
    );
  end

  if (AUTOFIRE_CYCLES == 0) begin : g_bad_autofire
    $error("AUTOFIRE_CYCLES must be nonzero");
  end

  // Treads, starts
  tread_pair_t t1, t2;
  assign t1 = map_stick(stick_t'(filt[3:0]));
  assign t2 = map_stick(stick_t'(filt[8:5]));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      {joyw_fw_n, joyw_bk_n, joyx_fw_n, joyx_bk_n} <= '1;
      {joyy_fw_n, joyy_bk_n, joyz_fw_n, joyz_bk_n} <= '1;
      start1_n <= 1'b1;
      start2_n <= 1'b1;
    end else begin
      {joyw_fw_n, joyw_bk_n, joyx_fw_n, joyx_bk_n} <= ~t1;
      {joyy_fw_n, joyy_bk_n, joyz_fw_n, joyz_bk_n} <= ~t2;
      start1_n <= ~filt[10];
      start2_n <= ~filt[11];
    end
  end

  // Fire
  logic [1:0] fire_filt, fire_q;
  assign fire_filt = {filt[9], filt[4]};

`ifdef TANK_CTRL_AUTOFIRE_EN
  localparam int unsigned   AW      = $clog2(AUTOFIRE_CYCLES) + 1;
  localparam logic [AW-1:0] AF_LAST = AW'(AUTOFIRE_CYCLES - 1);

  logic [1:0]    af_act_q;
  logic [AW-1:0] af_cnt_q [2];

  // First held cycle forces high and restarts the phase; afterwards the
  // output toggles each time the counter completes a half-period.
  always_ff @(posedge clk_sys) begin
    for (int unsigned p = 0; p < 2; p++) begin
      if (reset || !fire_filt[p]) begin
        fire_q[p]   <= 1'b0;
        af_act_q[p] <= 1'b0;
        af_cnt_q[p] <= '0;
      end else if (!af_act_q[p]) begin
        fire_q[p]   <= 1'b1;
        af_act_q[p] <= 1'b1;
        af_cnt_q[p] <= '0;
      end else if (af_cnt_q[p] == AF_LAST) begin
        fire_q[p]   <= ~fire_q[p];
        af_cnt_q[p] <= '0;
      end else begin
        af_cnt_q[p] <= af_cnt_q[p] + 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      fire_q <= '0;
    end else begin
      fire_q <= fire_filt;
    end
  end
`endif

  assign fire_a = fire_q[0];
  assign fire_b = fire_q[1];

  // Coin pulse shaper
  coin_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    pend_q, pend_d;
  logic          coin_n_q, coin_n_d;
  logic          coin_prev_q;
  logic          coin_edge, dequeue;

  assign coin_edge = filt[12] & ~coin_prev_q;
  assign dequeue   = (state_q == IDLE) && (pend_q != 2'd0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    coin_n_d = coin_n_q;
    pend_d   = pend_q;

    // Edge and dequeue together cancel out.
    if (coin_edge && !dequeue && pend_q != 2'd3) begin
      pend_d = pend_q + 2'd1;
    end else if (dequeue && !coin_edge) begin
      pend_d = pend_q - 2'd1;
    end

    unique case (state_q)
      IDLE: begin
        coin_n_d = 1'b1;
        if (dequeue) begin
          state_d  = PULSE;
          cnt_d    = '0;
          coin_n_d = 1'b0;
        end
      end
      PULSE: begin
        coin_n_d = 1'b0;
        if (cnt_q == PULSE_LAST) begin
          state_d  = GAP;
          cnt_d    = '0;
          coin_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        coin_n_d = 1'b1;
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        coin_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_q      <= '0;
      coin_n_q    <= 1'b1;
      coin_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      coin_n_q    <= coin_n_d;
      coin_prev_q <= filt[12];
    end
  end

  assign coin_n        = coin_n_q;
  assign coins_pending = pend_q;

endmodule

// File: tb/tb_tank_ctrl_conditioner.sv
// Self-checking bench for tank_ctrl_conditioner with short timing parameters.
// Define TANK_CTRL_AUTOFIRE_EN for both RTL and bench to exercise autofire.
module tb_tank_ctrl_conditioner;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [15:0] joy1, joy2;
  logic        joyw_fw_n, joyw_bk_n, joyx_fw_n, joyx_bk_n;
  logic        joyy_fw_n, joyy_bk_n, joyz_fw_n, joyz_bk_n;
  logic        fire_a, fire_b, start1_n, start2_n, coin_n;
  logic [1:0]  coins_pending;

  tank_ctrl_conditioner #(
    .DEBOUNCE_CYCLES   (4),
    .COIN_PULSE_CYCLES (8),
    .COIN_GAP_CYCLES   (8),
    .AUTOFIRE_CYCLES   (3)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .joy1          (joy1),
    .joy2          (joy2),
    .joyw_fw_n     (joyw_fw_n),
    .joyw_bk_n     (joyw_bk_n),
    .joyx_fw_n     (joyx_fw_n),
    .joyx_bk_n     (joyx_bk_n),
    .joyy_fw_n     (joyy_fw_n),
    .joyy_bk_n     (joyy_bk_n),
    .joyz_fw_n     (joyz_fw_n),
    .joyz_bk_n     (joyz_bk_n),
    .fire_a        (fire_a),
    .fire_b        (fire_b),
    .start1_n      (start1_n),
    .start2_n      (start2_n),
    .coin_n        (coin_n),
    .coins_pending (coins_pending)
  );

  always #5 clk_sys = ~clk_sys;

  // {w_fw, w_bk, x_fw, x_bk, y_fw, y_bk, z_fw, z_bk, fire_a, fire_b, start1_n, start2_n}
  logic [11:0] outs;
  assign outs = {joyw_fw_n, joyw_bk_n, joyx_fw_n, joyx_bk_n,
                 joyy_fw_n, joyy_bk_n, joyz_fw_n, joyz_bk_n,
                 fire_a, fire_b, start1_n, start2_n};
  localparam logic [11:0] IDLE_OUT = 12'hFF3;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Control-output scoreboard: expected vectors tagged with the cycle they are due.
  typedef struct {
    int unsigned when;
    logic [11:0] exp;
    string       tag;
  } exp_t;
  exp_t exp_q[$];

  task automatic push(input int unsigned when, input logic [11:0] exp, input string tag);
    exp_t e;
    e.when = when;
    e.exp  = exp;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  exp_t mon_e;
  always @(negedge clk_sys) begin
    while (exp_q.size() != 0 && exp_q[0].when <= cyc) begin
      mon_e = exp_q.pop_front();
      if (mon_e.when != cyc) check({mon_e.tag, "_missed"}, cyc, mon_e.when);
      else                   check(mon_e.tag, {20'd0, outs}, {20'd0, mon_e.exp});
    end
  end

  // Coin scoreboard: one expected pulse width per press.
  int unsigned coin_q[$];
  int unsigned lo_run = 0, hi_run = 0, pulses = 0;
  logic        first_pulse = 1'b1;
  logic [1:0]  peak = '0;
  int unsigned w_exp;

  always @(negedge clk_sys) begin
    if (reset) begin
      lo_run      = 0;
      hi_run      = 0;
      first_pulse = 1'b1;
    end else begin
      if (coins_pending > peak) peak = coins_pending;
      if (coin_n == 1'b0) begin
        if (lo_run == 0 && !first_pulse) check("coin_gap_ge8", {31'd0, hi_run >= 8}, 32'd1);
        lo_run++;
      end else if (lo_run != 0) begin
        pulses++;
        if (coin_q.size() == 0) begin
          check("coin_extra_pulse", pulses, 32'd0);
        end else begin
          w_exp = coin_q.pop_front();
          check("coin_width", lo_run, w_exp);
        end
        lo_run      = 0;
        hi_run      = 1;
        first_pulse = 1'b0;
      end else begin
        hi_run++;
      end
    end
  end

  task automatic coin_press(input logic use_p2, input int unsigned hi, input int unsigned lo);
    if (use_p2) joy2[7] = 1'b1; else joy1[7] = 1'b1;
    coin_q.push_back(8);
    step(hi);
    joy1[7] = 1'b0;
    joy2[7] = 1'b0;
    step(lo);
  endtask

  task automatic wait_coins(input string tag);
    int unsigned n = 0;
    while ((coin_q.size() != 0 || coin_n !== 1'b1 || coins_pending != 2'd0) && n < 400) begin
      step(1);
      n++;
    end
    check({tag, "_drained"}, coin_q.size(), 32'd0);
    check({tag, "_pending0"}, {30'd0, coins_pending}, 32'd0);
  endtask

  typedef struct {
    logic [15:0] j1;
    logic [15:0] j2;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[14] = '{
    '{16'h0008, 16'h0000, 12'h5F3},  // P1 up
    '{16'h000C, 16'h0000, 12'hFF3},  // P1 up+down
    '{16'h0000, 16'h000A, 12'hFD3},  // P2 up+left
    '{16'h0001, 16'h0000, 12'h6F3},  // P1 right
    '{16'h0002, 16'h0000, 12'h9F3},  // P1 left
    '{16'h0004, 16'h0000, 12'hAF3},  // P1 down
    '{16'h0005, 16'h0000, 12'hBF3},  // P1 down+right
    '{16'h0000, 16'h0006, 12'hFE3},  // P2 down+left
    '{16'h0000, 16'h0009, 12'hF73},  // P2 up+right
    '{16'h0010, 16'h0020, 12'hFF9},  // P1 fire, start1 via P2
    '{16'h0040, 16'h0010, 12'hFF6},  // start2 via P1, P2 fire
    '{16'h000F, 16'h0000, 12'hFF3},  // P1 all four directions
    '{16'h0003, 16'h0000, 12'hFF3},  // P1 left+right
    '{16'h0000, 16'h0000, 12'hFF3}
  };

  initial begin
    int unsigned base;
    int unsigned n;
    reset = 1'b1;
    joy1  = '0;
    joy2  = '0;
    step(3);
    reset = 1'b0;
    step(1);
    check("rst_ctrl", {20'd0, outs}, {20'd0, IDLE_OUT});
    check("rst_coin_n", {31'd0, coin_n}, 32'd1);
    check("rst_pending", {30'd0, coins_pending}, 32'd0);

    // Tread/fire/start table: new value due exactly DEBOUNCE+1 cycles later.
    foreach (tbl[i]) begin
      joy1 = tbl[i].j1;
      joy2 = tbl[i].j2;
      base = cyc;
      push(base + 4, (i == 0) ? IDLE_OUT : tbl[i-1].exp, $sformatf("tbl%0d_hold", i));
      push(base + 5, tbl[i].exp, $sformatf("tbl%0d_at5", i));
      push(base + 7, tbl[i].exp, $sformatf("tbl%0d_at7", i));
      step(10);
    end

    // Three-cycle glitch on P1 up must not reach the outputs.
    joy1 = 16'h0008;
    step(3);
    joy1 = '0;
    base = cyc;
    for (int k = 1; k <= 8; k++) push(base + k, IDLE_OUT, "glitch");
    step(10);

`ifdef TANK_CTRL_AUTOFIRE_EN
    joy1 = 16'h0010;
    base = cyc;
    for (int k = 0; k < 15; k++)
      push(base + 5 + k, (((k / 3) % 2) == 0) ? 12'hFFB : IDLE_OUT, $sformatf("autofire%0d", k));
    step(20);
    joy1 = '0;
    push(cyc + 5, IDLE_OUT, "autofire_release");
    step(10);
`endif

    // Three presses 6 high / 6 low: three 8-cycle pulses, at most one queued.
    peak   = '0;
    pulses = 0;
    coin_press(1'b0, 6, 6);
    coin_press(1'b1, 6, 6);
    coin_press(1'b0, 6, 6);
    wait_coins("burst3");
    check("burst3_pulses", pulses, 32'd3);
    check("burst3_peak", {30'd0, peak}, 32'd1);

    // Four presses 5 high / 5 low: queue builds to two.
    peak   = '0;
    pulses = 0;
    for (int k = 0; k < 4; k++) coin_press(1'b0, 5, 5);
    wait_coins("burst4");
    check("burst4_pulses", pulses, 32'd4);
    check("burst4_peak", {30'd0, peak}, 32'd2);

    // Reset in the middle of a pulse.
    coin_press(1'b0, 6, 0);
    n = 0;
    while (coin_n !== 1'b0 && n < 20) begin
      step(1);
      n++;
    end
    check("midrst_pulse_started", {31'd0, coin_n}, 32'd0);
    step(3);
    coin_q.delete();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("midrst_coin_n", {31'd0, coin_n}, 32'd1);
    check("midrst_pending", {30'd0, coins_pending}, 32'd0);
    step(2);
    pulses = 0;
    coin_press(1'b0, 6, 6);
    wait_coins("after_rst");
    check("after_rst_pulses", pulses, 32'd1);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step(1);
      n++;
    end
    check("sb_leftover", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
